axi_lite_ipif_bridge: RTL and testbench

AXI_LITE_IPIF_BRIDGE -- requirements
Module: axi_lite_ipif_bridge

---
 rtl/axi_ipif_pkg.sv | 16 +
 rtl/ipif_addr_decode.sv | 25 ++
 rtl/axi_lite_ipif_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_axi_lite_ipif_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ipif_pkg.sv
// AXI-Lite to IPIF bridge shared definitions.
// Response codes and bridge FSM encoding.
package axi_ipif_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_WR_RESP,
    ST_RD_WAIT,
    ST_RD_RESP
  } state_t;

endpackage

// File: rtl/ipif_addr_decode.sv
// Byte address to one-hot IPIF chip enable.
// Flags addresses beyond the register window.
module ipif_addr_decode #(
  parameter int C_NUM_REGS = 4
) (
  input  logic [31:0]                   addr,
  output logic [C_NUM_REGS-1:0]         ce,
  output logic [$clog2(C_NUM_REGS)-1:0] idx,
  output logic                          oor
);

  localparam int IW = $clog2(C_NUM_REGS);

  logic unused_lsb;

  assign unused_lsb = ^addr[1:0];
  assign idx = addr[IW+1:2];
  assign oor = |addr[31:IW+2];

  always_comb begin
    ce = '0;
    if (!oor) ce[idx] = 1'b1;
  end

endmodule

// File: rtl/axi_lite_ipif_bridge.sv
// AXI4-Lite slave to IPIF register bridge.
// Buffers AW/W, arbitrates with AR, times out IPIF acks.
module axi_lite_ipif_bridge
  import axi_ipif_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_REGS   = 4,
  parameter int C_TIMEOUT    = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [31:0]            AWADDR,
  input  logic                   WVALID,
  output logic                   WREADY,
  input  logic [C_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] WSTRB,
  output logic                   BVALID,
  input  logic                   BREADY,
  output logic [1:0]             BRESP,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  input  logic [31:0]            ARADDR,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic [C_DATA_WIDTH-1:0] RDATA,
  output logic [1:0]             RRESP,
  output logic [C_DATA_WIDTH-1:0]   bus2ip_data,
  output logic [C_DATA_WIDTH/8-1:0] bus2ip_be,
  output logic [C_NUM_REGS-1:0]  bus2ip_wrce,
  output logic [C_NUM_REGS-1:0]  bus2ip_rdce,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] ip2bus_data,
  input  logic                   ip2bus_wrack,
  input  logic                   ip2bus_rdack
);

  localparam int IW = $clog2(C_NUM_REGS);
  localparam int CW = $clog2(C_TIMEOUT + 1);

  state_t          st;
  logic            aw_full;
  logic            w_full;
  logic            last_wr;
  logic [31:0]     aw_addr;
  logic [IW-1:0]   rd_idx;
  logic [CW-1:0]   cnt;

  logic [C_NUM_REGS-1:0] wr_ce;
  logic [C_NUM_REGS-1:0] rd_ce;
  logic [IW-1:0]   unused_wr_idx;
  logic [IW-1:0]   rd_idx_d;
  logic            wr_oor;
  logic            rd_oor;

  logic aw_hs, w_hs, ar_hs;
  logic aw_full_n, w_full_n;
  logic pair, tmo;

  ipif_addr_decode #(.C_NUM_REGS(C_NUM_REGS)) u_wr_dec (
    .addr (aw_addr),
    .ce   (wr_ce),
    .idx  (unused_wr_idx),
    .oor  (wr_oor)
  );

  ipif_addr_decode #(.C_NUM_REGS(C_NUM_REGS)) u_rd_dec (
    .addr (ARADDR),
    .ce   (rd_ce),
    .idx  (rd_idx_d),
    .oor  (rd_oor)
  );

  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign ar_hs     = ARVALID && ARREADY;
  assign aw_full_n = aw_full | aw_hs;
  assign w_full_n  = w_full | w_hs;
  assign pair      = aw_full && w_full;
  assign tmo       = (cnt == CW'(C_TIMEOUT - 1));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      st          <= ST_IDLE;
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      last_wr     <= 1'b1;
      aw_addr     <= '0;
      rd_idx      <= '0;
      cnt         <= '0;
      AWREADY     <= 1'b0;
      WREADY      <= 1'b0;
      ARREADY     <= 1'b0;
      BVALID      <= 1'b0;
      BRESP       <= RESP_OKAY;
      RVALID      <= 1'b0;
      RRESP       <= RESP_OKAY;
      RDATA       <= '0;
      bus2ip_data <= '0;
      bus2ip_be   <= '0;
      bus2ip_wrce <= '0;
      bus2ip_rdce <= '0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          cnt <= '0;
          if (aw_hs) begin
            aw_full <= 1'b1;
            aw_addr <= AWADDR;
          end
          if (w_hs) begin
            w_full      <= 1'b1;
            bus2ip_data <= WDATA;
            bus2ip_be   <= WSTRB;
          end
          // ARREADY is only offered when read may win arbitration
          if (ar_hs) begin
            last_wr <= 1'b0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            ARREADY <= 1'b0;
            rd_idx  <= rd_idx_d;
            if (rd_oor) begin
              st     <= ST_RD_RESP;
              RVALID <= 1'b1;
              RRESP  <= RESP_SLVERR;
              RDATA  <= '0;
            end else begin
              st          <= ST_RD_WAIT;
              bus2ip_rdce <= rd_ce;
            end
          end else if (pair) begin
            last_wr <= 1'b1;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            ARREADY <= 1'b0;
            if (wr_oor) begin
              st     <= ST_WR_RESP;
              BVALID <= 1'b1;
              BRESP  <= RESP_SLVERR;
            end else begin
              st          <= ST_WR_WAIT;
              bus2ip_wrce <= wr_ce;
            end
          end else begin
            AWREADY <= !aw_full_n;
            WREADY  <= !w_full_n;
            ARREADY <= !(aw_full_n && w_full_n)
                       || last_wr;
          end
        end
        ST_WR_WAIT: begin
          if (ip2bus_wrack || tmo) begin
            bus2ip_wrce <= '0;
            BVALID      <= 1'b1;
            BRESP       <= ip2bus_wrack ? RESP_OKAY
                                        : RESP_SLVERR;
            st          <= ST_WR_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            ARREADY <= 1'b1;
            st      <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (ip2bus_rdack || tmo) begin
            bus2ip_rdce <= '0;
            RVALID      <= 1'b1;
            st          <= ST_RD_RESP;
            if (ip2bus_rdack) begin
              RDATA <= ip2bus_data[int'(rd_idx)*C_DATA_WIDTH
                                   +: C_DATA_WIDTH];
              RRESP <= RESP_OKAY;
            end else begin
              RDATA <= '0;
              RRESP <= RESP_SLVERR;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RD_RESP: begin
          // a write pair that lost arbitration stays buffered
          if (RREADY) begin
            RVALID  <= 1'b0;
            AWREADY <= !aw_full;
            WREADY  <= !w_full;
            ARREADY <= !(aw_full && w_full);
            st      <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_ipif_bridge.sv
// Randomized self-checking bench for axi_lite_ipif_bridge.
// Bench emulates the IPIF register file and keeps its own model.
module tb_axi_lite_ipif_bridge;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 16;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic AWVALID, AWREADY, WVALID, WREADY;
  logic [31:0] AWADDR, ARADDR;
  logic [DW-1:0] WDATA, RDATA, bus2ip_data;
  logic [DW/8-1:0] WSTRB, bus2ip_be;
  logic BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0] BRESP, RRESP;
  logic [NR-1:0] bus2ip_wrce, bus2ip_rdce;
  logic [NR*DW-1:0] ip2bus_data;
  logic ip2bus_wrack, ip2bus_rdack;

  logic [31:0] ip_regs [NR];
  logic [31:0] mdl [NR];
  int errs = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  always_comb begin
    ip2bus_data = '0;
    for (int i = 0; i < NR; i++)
      ip2bus_data[i*DW +: DW] = ip_regs[i];
  end

  axi_lite_ipif_bridge #(
    .C_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_TIMEOUT(TO)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY),
    .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY),
    .RDATA(RDATA), .RRESP(RRESP),
    .bus2ip_data(bus2ip_data), .bus2ip_be(bus2ip_be),
    .bus2ip_wrce(bus2ip_wrce), .bus2ip_rdce(bus2ip_rdce),
    .ip2bus_data(ip2bus_data),
    .ip2bus_wrack(ip2bus_wrack), .ip2bus_rdack(ip2bus_rdack)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic ip_apply;
    for (int k = 0; k < NR; k++)
      if (bus2ip_wrce[k])
        ip_regs[k] = merge(ip_regs[k], bus2ip_data, bus2ip_be);
  endtask

  task automatic do_write(input logic [31:0] addr,
                          input logic [31:0] data,
                          input logic [3:0] strb,
                          input int dly, input int wlead,
                          input int bdly);
    bit awd = 0, wd = 0, ah, wh, got = 0, oor, tmo, early = 0;
    int t = 0, ce_cyc = 0, idx, exp_ce;
    logic [3:0] onehot;
    logic [1:0] exp_r;
    oor = (addr >> 4) != 0;
    idx = int'((addr >> 2) & 3);
    tmo = !oor && dly >= TO;
    onehot = 4'(1 << idx);
    exp_ce = oor ? 0 : (tmo ? TO : dly + 1);
    exp_r = (oor || tmo) ? 2'b10 : 2'b00;
    while (!got && t < 200) begin
      if (BVALID) got = 1;
      else begin
        if (bus2ip_wrce != 0) begin
          ce_cyc++;
          if (!(awd && wd)) early = 1;
          if (ce_cyc == 1) begin
            chk("wrce", bus2ip_wrce, onehot);
            chk("wdata", bus2ip_data, data);
            chk("wbe", bus2ip_be, strb);
          end
        end
        ip2bus_wrack = bus2ip_wrce != 0 && ce_cyc == dly + 1;
        if (ip2bus_wrack) ip_apply();
        AWVALID = !awd && t >= wlead;
        AWADDR = addr;
        WVALID = !wd;
        WDATA = data;
        WSTRB = strb;
        ah = AWVALID && AWREADY;
        wh = WVALID && WREADY;
        tick;
        awd |= ah;
        wd |= wh;
        ip2bus_wrack = 0;
        t++;
      end
    end
    AWVALID = 0;
    WVALID = 0;
    chk("b_seen", got, 1);
    chk("wr_ce_cycles", ce_cyc, exp_ce);
    chk("early_ce", early, 0);
    chk("bresp", BRESP, exp_r);
    if (tmo) begin
      ip2bus_wrack = 1;
      tick;
      ip2bus_wrack = 0;
    end
    repeat (bdly) tick;
    chk("bvalid_hold", BVALID, 1);
    chk("bresp_hold", BRESP, exp_r);
    BREADY = 1;
    tick;
    BREADY = 0;
    chk("b_done", BVALID, 0);
    chk("rdy_back_w", {AWREADY, WREADY, ARREADY}, 3'b111);
    if (!oor && !tmo) mdl[idx] = merge(mdl[idx], data, strb);
  endtask

  task automatic do_read(input logic [31:0] addr,
                         input int dly, input int rdly);
    bit done = 0, hs, got = 0, oor, tmo;
    int t = 0, ce_cyc = 0, idx, exp_ce;
    logic [3:0] onehot;
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    oor = (addr >> 4) != 0;
    idx = int'((addr >> 2) & 3);
    tmo = !oor && dly >= TO;
    onehot = 4'(1 << idx);
    exp_ce = oor ? 0 : (tmo ? TO : dly + 1);
    exp_d = (oor || tmo) ? 32'h0 : mdl[idx];
    exp_r = (oor || tmo) ? 2'b10 : 2'b00;
    while (!got && t < 200) begin
      if (RVALID) got = 1;
      else begin
        if (bus2ip_rdce != 0) begin
          ce_cyc++;
          if (ce_cyc == 1) chk("rdce", bus2ip_rdce, onehot);
        end
        ip2bus_rdack = bus2ip_rdce != 0 && ce_cyc == dly + 1;
        ARVALID = !done;
        ARADDR = addr;
        hs = ARVALID && ARREADY;
        tick;
        done |= hs;
        ip2bus_rdack = 0;
        t++;
      end
    end
    ARVALID = 0;
    chk("r_seen", got, 1);
    chk("rd_ce_cycles", ce_cyc, exp_ce);
    chk("rdata", RDATA, exp_d);
    chk("rresp", RRESP, exp_r);
    if (tmo) begin
      ip2bus_rdack = 1;
      tick;
      ip2bus_rdack = 0;
    end
    repeat (rdly) tick;
    chk("rdata_hold", RDATA, exp_d);
    chk("rvalid_hold", RVALID, 1);
    RREADY = 1;
    tick;
    RREADY = 0;
    chk("r_done", RVALID, 0);
    chk("rdy_back_r", {AWREADY, WREADY, ARREADY}, 3'b111);
  endtask

  task automatic do_coincide(input logic [31:0] waddr,
                             input logic [31:0] wdata,
                             input logic [31:0] raddr);
    bit awd = 0, wd = 0, ard = 0, gb = 0, gr = 0, both = 0;
    bit ah, wh, rh;
    int first = 0, t = 0, widx, ridx;
    logic [31:0] exp_d;
    widx = int'((waddr >> 2) & 3);
    ridx = int'((raddr >> 2) & 3);
    exp_d = mdl[ridx];
    BREADY = 1;
    RREADY = 1;
    while (!(gb && gr) && t < 200) begin
      if (BVALID) begin
        gb = 1;
        chk("co_bresp", BRESP, 2'b00);
      end
      if (RVALID) begin
        gr = 1;
        chk("co_rdata", RDATA, exp_d);
        chk("co_rresp", RRESP, 2'b00);
      end
      if (bus2ip_wrce != 0 && bus2ip_rdce != 0) both = 1;
      if (first == 0 && bus2ip_rdce != 0) first = 1;
      if (first == 0 && bus2ip_wrce != 0) first = 2;
      ip2bus_wrack = bus2ip_wrce != 0;
      ip2bus_rdack = bus2ip_rdce != 0;
      if (ip2bus_wrack) ip_apply();
      AWVALID = !awd;
      AWADDR = waddr;
      WVALID = !wd;
      WDATA = wdata;
      WSTRB = 4'hF;
      ARVALID = !ard;
      ARADDR = raddr;
      ah = AWVALID && AWREADY;
      wh = WVALID && WREADY;
      rh = ARVALID && ARREADY;
      tick;
      awd |= ah;
      wd |= wh;
      ard |= rh;
      ip2bus_wrack = 0;
      ip2bus_rdack = 0;
      t++;
    end
    AWVALID = 0;
    WVALID = 0;
    ARVALID = 0;
    BREADY = 0;
    RREADY = 0;
    chk("co_done", {gb, gr}, 2'b11);
    chk("co_first", first, 1);
    chk("co_one_ce", both, 0);
    mdl[widx] = wdata;
    tick;
  endtask

  initial begin
    int t;
    bit saw;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    AWADDR = 0; ARADDR = 0; WDATA = 0; WSTRB = 0;
    BREADY = 0; RREADY = 0;
    ip2bus_wrack = 0; ip2bus_rdack = 0;
    for (int i = 0; i < NR; i++) begin
      ip_regs[i] = $urandom;
      mdl[i] = ip_regs[i];
    end
    ARESETn = 0;
    tick;
    tick;
    chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("rst_valid", {BVALID, RVALID}, 2'b00);
    chk("rst_ce", {bus2ip_wrce, bus2ip_rdce}, 8'h00);
    chk("rst_rdata", RDATA, 32'h0);
    ARESETn = 1;
    tick;
    chk("rdy_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);

    do_write(32'h4, 32'hA5A5A5A5, 4'hF, 2, 0, 1);
    do_write(32'hC, 32'h0BADF00D, 4'hF, 1, 3, 0);
    ip_regs[2] = 32'h12345678;
    mdl[2] = 32'h12345678;
    do_read(32'h8, 1, 4);
    do_read(32'h40, 0, 0);
    do_write(32'h0, 32'h00000001, 4'hF, 99, 0, 0);
    do_read(32'hC, 15, 0);
    do_coincide(32'h4, 32'hCAFE0001, 32'h4);
    do_coincide(32'h8, 32'hCAFE0002, 32'hC);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int d, sel;
      sel = int'($urandom_range(0, 9));
      d = (sel <= 6) ? sel : (sel == 7 ? 15 : (sel == 8 ? 99 : 0));
      if ($urandom_range(0, 5) == 0)
        a = ($urandom_range(1, 1000) << 4) | $urandom_range(0, 15);
      else
        a = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), d,
                 int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)));
      else
        do_read(a, d, int'($urandom_range(0, 3)));
    end

    AWVALID = 1;
    AWADDR = 32'h0;
    WVALID = 1;
    WDATA = 32'hDEADBEEF;
    WSTRB = 4'hF;
    tick;
    AWVALID = 0;
    WVALID = 0;
    t = 0;
    while (bus2ip_wrce == 0 && t < 20) begin
      tick;
      t++;
    end
    chk("inflight_wrce", bus2ip_wrce, 4'b0001);
    tick;
    #2 ARESETn = 0;
    #1;
    chk("async_rst_wrce", bus2ip_wrce, 4'b0000);
    chk("async_rst_bvalid", BVALID, 0);
    chk("async_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    tick;
    ARESETn = 1;
    tick;
    chk("rdy_after_pulse", {AWREADY, WREADY, ARREADY}, 3'b111);
    saw = 0;
    repeat (5) begin
      if (BVALID || bus2ip_wrce != 0) saw = 1;
      tick;
    end
    chk("no_resp_after_rst", saw, 0);
    do_read(32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
